treehash_stack: RTL and testbench

TREEHASH_STACK -- requirements
Module: treehash_stack

---
 rtl/treehash_stack.sv | 168 ++++++++++++++++
 tb/tb_treehash_stack.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/treehash_stack.sv
// XMSS treehash: folds a stream of 2^TREE_HEIGHT leaves into a Merkle root using an external hash core.
// Define TREEHASH_PERF_CNT_EN to add a 32-bit cycle_count output (start acceptance through FINISH).
module treehash_stack #(
  parameter int TREE_HEIGHT           = 10,
  parameter int KEY_LEN               = 256,
  parameter int XMSS_HASH_PADDING_H   = 1,
  parameter int XMSS_HASH_PADDING_PRF = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [KEY_LEN-1:0] pub_seed,
  input  logic [255:0]       hash_addr,
  input  logic [KEY_LEN-1:0] leaf_in,
  input  logic               leaf_valid,
  output logic               leaf_ready,
  output logic [KEY_LEN-1:0] root_out,
  output logic               done,
  output logic               busy,
  output logic               hash_start,
  output logic [1023:0]      hash_data_in,
  output logic               message_length,
  output logic               store_intermediate,
  output logic               continue_intermediate,
`ifdef TREEHASH_PERF_CNT_EN
  output logic [31:0]        cycle_count,
`endif
  input  logic               hash_done,
  input  logic [KEY_LEN-1:0] hash_data_out
);
  localparam int DEPTH = TREE_HEIGHT + 1;
  localparam int SPW   = $clog2(DEPTH + 1);
  localparam int HW    = $clog2(TREE_HEIGHT + 1);
  localparam int CW    = TREE_HEIGHT + 1;
  localparam logic [CW-1:0] NLEAF = CW'(1) << TREE_HEIGHT;

  typedef enum logic [2:0] {
    IDLE, WAIT_LEAF, CHECK, PRF_KEY, PRF_BM0, PRF_BM1, HASH_H, FINISH
  } state_t;

  state_t             state_q;
  logic [SPW-1:0]     sp_q;
  logic [CW-1:0]      leaf_cnt_q;
  logic [KEY_LEN-1:0] seed_q, key_q, bm0_q, root_q;
  logic [255:0]       addr_q;
  logic [KEY_LEN-1:0] node_q [DEPTH];
  logic [HW-1:0]      hgt_q  [DEPTH];
  logic               done_q, hash_start_q, msg_len_q;
  logic [1023:0]      hash_data_q;

  logic [SPW-1:0]     top_idx, sec_idx;
  logic [HW-1:0]      top_h;
  logic [CW-1:0]      tree_idx;
  logic               merge_ok;
  logic [255:0]       addr_base;
  logic [735:0]       prf_hi;
  logic [1023:0]      h_msg;

  always_comb begin
    top_idx  = sp_q - SPW'(1);
    sec_idx  = sp_q - SPW'(2);
    top_h    = hgt_q[top_idx];
    merge_ok = (sp_q >= SPW'(2)) && (hgt_q[top_idx] == hgt_q[sec_idx]);
    tree_idx = (leaf_cnt_q - CW'(1)) >> (int'(top_h) + 1);
    addr_base          = addr_q;
    addr_base[159:128] = 32'd2;
    addr_base[95:64]   = 32'(top_h);
    addr_base[63:32]   = 32'(tree_idx);
    addr_base[31:0]    = 32'd0;
    // PRF message minus the key_and_mask word and the zero tail
    prf_hi = {256'(XMSS_HASH_PADDING_PRF), 256'(seed_q), addr_base[255:32]};
    // bm1 is taken straight from the hash core since it arrives on the same edge
    h_msg  = {256'(XMSS_HASH_PADDING_H), 256'(key_q),
              256'(node_q[sec_idx] ^ bm0_q), 256'(node_q[top_idx] ^ hash_data_out)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sp_q         <= '0;
      leaf_cnt_q   <= '0;
      done_q       <= 1'b0;
      hash_start_q <= 1'b0;
      root_q       <= '0;
      hash_data_q  <= '0;
      msg_len_q    <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      hash_start_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          seed_q     <= pub_seed;
          addr_q     <= hash_addr;
          sp_q       <= '0;
          leaf_cnt_q <= '0;
          state_q    <= WAIT_LEAF;
        end
        WAIT_LEAF: if (leaf_valid) begin
          node_q[sp_q] <= leaf_in;
          hgt_q[sp_q]  <= '0;
          sp_q         <= sp_q + SPW'(1);
          leaf_cnt_q   <= leaf_cnt_q + CW'(1);
          state_q      <= CHECK;
        end
        CHECK: begin
          if (merge_ok) begin
            state_q      <= PRF_KEY;
            hash_start_q <= 1'b1;
            hash_data_q  <= {prf_hi, 32'd0, 256'd0};
            msg_len_q    <= 1'b0;
          end else if (leaf_cnt_q == NLEAF && sp_q == SPW'(1)) begin
            state_q <= FINISH;
            done_q  <= 1'b1;
            root_q  <= node_q[0];
          end else begin
            state_q <= WAIT_LEAF;
          end
        end
        PRF_KEY: if (hash_done) begin
          key_q        <= hash_data_out;
          state_q      <= PRF_BM0;
          hash_start_q <= 1'b1;
          hash_data_q  <= {prf_hi, 32'd1, 256'd0};
        end
        PRF_BM0: if (hash_done) begin
          bm0_q        <= hash_data_out;
          state_q      <= PRF_BM1;
          hash_start_q <= 1'b1;
          hash_data_q  <= {prf_hi, 32'd2, 256'd0};
        end
        PRF_BM1: if (hash_done) begin
          state_q      <= HASH_H;
          hash_start_q <= 1'b1;
          hash_data_q  <= h_msg;
          msg_len_q    <= 1'b1;
        end
        HASH_H: if (hash_done) begin
          node_q[sec_idx] <= hash_data_out;
          hgt_q[sec_idx]  <= top_h + HW'(1);
          sp_q            <= sp_q - SPW'(1);
          state_q         <= CHECK;
        end
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef TREEHASH_PERF_CNT_EN
  logic [31:0] cycle_q;
  always_ff @(posedge clk) begin
    if (reset)                 cycle_q <= '0;
    else if (state_q != IDLE)  cycle_q <= cycle_q + 32'd1;
    else if (start)            cycle_q <= 32'd1;
  end
  assign cycle_count = cycle_q;
`endif

  assign leaf_ready            = (state_q == WAIT_LEAF);
  assign busy                  = (state_q != IDLE);
  assign done                  = done_q;
  assign hash_start            = hash_start_q;
  assign hash_data_in          = hash_data_q;
  assign message_length        = msg_len_q;
  assign root_out              = root_q;
  assign store_intermediate    = 1'b0;
  assign continue_intermediate = 1'b0;
endmodule

// File: tb/tb_treehash_stack.sv
// Bench for treehash_stack: height-2 trees against a reference treehash using a toy hash core model.
module tb_treehash_stack;
  localparam int TH = 2;

  logic         clk = 1'b0;
  logic         reset, start, leaf_valid;
  logic [255:0] pub_seed, hash_addr, leaf_in;
  logic         leaf_ready, done, busy, hash_start, message_length;
  logic         store_intermediate, continue_intermediate;
  logic [255:0] root_out;
  logic [1023:0] hash_data_in;
  logic         hash_done;
  logic [255:0] hash_data_out;
`ifdef TREEHASH_PERF_CNT_EN
  logic [31:0]  cycle_count;
`endif

  always #5 clk = ~clk;

  treehash_stack #(.TREE_HEIGHT(TH), .KEY_LEN(256)) dut (
    .clk(clk), .reset(reset), .start(start), .pub_seed(pub_seed), .hash_addr(hash_addr),
    .leaf_in(leaf_in), .leaf_valid(leaf_valid), .leaf_ready(leaf_ready), .root_out(root_out),
    .done(done), .busy(busy), .hash_start(hash_start), .hash_data_in(hash_data_in),
    .message_length(message_length), .store_intermediate(store_intermediate),
    .continue_intermediate(continue_intermediate),
`ifdef TREEHASH_PERF_CNT_EN
    .cycle_count(cycle_count),
`endif
    .hash_done(hash_done), .hash_data_out(hash_data_out)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string nm, input logic [1024:0] act, input logic [1024:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Toy hash core: any bit of the message or its length changes the digest
  function automatic logic [255:0] hmodel(input logic [1023:0] d, input logic ml);
    logic [255:0] c0, c1, c2, c3, r;
    c0 = d[1023:768]; c1 = d[767:512]; c2 = d[511:256]; c3 = d[255:0];
    r = {c0[250:0], c0[255:251]} ^ {c1[236:0], c1[255:237]} ^
        (c2 + {c3[127:0], c3[255:128]}) ^ (c3 * 256'd3);
    r = r ^ {r[200:0], r[255:201]};
    if (ml) r = ~r;
    return r;
  endfunction

  // Hash core: latency 0 answers combinationally, otherwise after hash_lat cycles
  int           hash_lat = 0;
  logic         stale_done = 1'b0;
  logic         pend = 1'b0;
  int           lat_cnt = 0;
  logic [255:0] lat_data = '0;
  assign hash_done     = stale_done | ((hash_lat == 0) ? hash_start : (pend && lat_cnt == 0));
  assign hash_data_out = (hash_lat == 0) ? hmodel(hash_data_in, message_length) : lat_data;

  always @(posedge clk) begin
    cyc++;
    if (hash_start && hash_lat != 0) begin
      pend     <= 1'b1;
      lat_cnt  <= hash_lat - 1;
      lat_data <= hmodel(hash_data_in, message_length);
    end else if (pend) begin
      if (lat_cnt == 0) pend <= 1'b0;
      else              lat_cnt <= lat_cnt - 1;
    end
  end

  // Scoreboard: expected hash requests and roots, pushed when a tree is launched
  logic [1024:0] exp_q[$];
  logic [255:0]  root_exp_q[$];
  int            nhash = 0, ndone = 0, viol = 0, done_cyc = 0, first_n = 0;
  logic [1023:0] first_req[4];
  logic          first_ml[4];

  always @(negedge clk) begin
    if (hash_start) begin
      nhash++;
      if (first_n < 4) begin
        first_req[first_n] = hash_data_in;
        first_ml[first_n]  = message_length;
        first_n++;
      end
      if (exp_q.size() == 0) chk("hash_req_unexpected", {message_length, hash_data_in}, '0);
      else chk("hash_req", {message_length, hash_data_in}, exp_q.pop_front());
    end
    if ((hash_start || hash_done) && leaf_ready) viol++;
    if (done) begin
      ndone++;
      done_cyc = cyc;
      if (root_exp_q.size() == 0) chk("done_unexpected", 1025'(done), 1025'(0));
      else chk("root_at_done", 1025'(root_out), 1025'(root_exp_q.pop_front()));
    end
  end

  task automatic ref_tree(input logic [255:0] seed, input logic [255:0] addr,
                          input logic [255:0] lv[4], input bit push, output logic [255:0] root);
    logic [255:0]  sn[3];
    int            sh[3];
    int            sp, h;
    logic [255:0]  a;
    logic [255:0]  k[3];
    logic [1023:0] m;
    sp = 0;
    for (int idx = 0; idx < 4; idx++) begin
      sn[sp] = lv[idx]; sh[sp] = 0; sp++;
      while (sp >= 2 && sh[sp-1] == sh[sp-2]) begin
        h = sh[sp-1];
        a = addr;
        a[159:128] = 32'd2;
        a[95:64]   = 32'(h);
        a[63:32]   = 32'(idx >> (h + 1));
        for (int j = 0; j < 3; j++) begin
          a[31:0] = 32'(j);
          m = {256'd3, seed, a, 256'd0};
          if (push) exp_q.push_back({1'b0, m});
          k[j] = hmodel(m, 1'b0);
        end
        m = {256'd1, k[0], sn[sp-2] ^ k[1], sn[sp-1] ^ k[2]};
        if (push) exp_q.push_back({1'b1, m});
        sn[sp-2] = hmodel(m, 1'b1);
        sh[sp-2] = h + 1;
        sp--;
      end
    end
    root = sn[0];
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
    return r;
  endfunction

  typedef struct {
    logic [255:0] seed;
    logic [255:0] addr;
    logic [255:0] lv[4];
    int           lat;
    int           gap;
    bit           hold;
    bit           mid;
    logic [255:0] exp_root;
    int           exp_hashes;
  } vec_t;

  vec_t vecs[4];

  task automatic feed_leaf(input logic [255:0] l);
    int t;
    leaf_in = l; leaf_valid = 1'b1; t = 0;
    while (!leaf_ready && t < 300) begin @(negedge clk); t++; end
    chk("leaf_handshake", 1025'(leaf_ready), 1025'(1));
    @(negedge clk);
  endtask

  task automatic run_tree(input vec_t v);
    int           t, start_cyc;
    logic [255:0] r;
    exp_q.delete(); root_exp_q.delete();
    nhash = 0; ndone = 0; viol = 0; first_n = 0;
    ref_tree(v.seed, v.addr, v.lv, 1'b1, r);
    root_exp_q.push_back(v.exp_root);
    hash_lat = v.lat;
    pub_seed = v.seed; hash_addr = v.addr; start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0; pub_seed = ~v.seed; hash_addr = ~v.addr;
    for (int i = 0; i < 4; i++) begin
      feed_leaf(v.lv[i]);
      if (v.mid && i == 1) begin
        start = 1'b1; @(negedge clk); start = 1'b0;
      end
      if (!v.hold) begin
        leaf_valid = 1'b0;
        repeat (v.gap) @(negedge clk);
      end
    end
    leaf_in = ~v.lv[3];
    t = 0;
    while (ndone == 0 && t < 2000) begin @(negedge clk); t++; end
    leaf_valid = 1'b0;
    chk("done_timeout", 1025'(ndone > 0), 1025'(1));
    repeat (3) @(negedge clk);
    chk("done_pulses", 1025'(ndone), 1025'(1));
    chk("hash_count", 1025'(nhash), 1025'(v.exp_hashes));
    chk("sb_drained", 1025'(exp_q.size()), 1025'(0));
    chk("leaf_ready_in_merge", 1025'(viol), 1025'(0));
    chk("root_hold", 1025'(root_out), 1025'(v.exp_root));
    chk("busy_after", 1025'(busy), 1025'(0));
`ifdef TREEHASH_PERF_CNT_EN
    chk("cycle_count", 1025'(cycle_count), 1025'(done_cyc - start_cyc + 1));
`endif
    if (v.addr == '0) begin
      chk("m1_word3", 1025'(first_req[0][415:384]), 1025'(2));
      chk("m1_word5", 1025'(first_req[0][351:320]), 1025'(0));
      chk("m1_word6", 1025'(first_req[0][319:288]), 1025'(0));
      for (int j = 0; j < 3; j++) begin
        chk("m1_word7", 1025'(first_req[j][287:256]), 1025'(j));
        chk("m1_prf_len", 1025'(first_ml[j]), 1025'(0));
      end
      chk("m1_h_len", 1025'(first_ml[3]), 1025'(1));
    end
    $display("[TB] tree lat=%0d hold=%0d mid=%0d hashes=%0d root=%h", v.lat, v.hold, v.mid, nhash, root_out);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    logic [255:0] r;
    int t, bad;
    for (int i = 0; i < 4; i++) begin
      vecs[i].seed = rnd256();
      vecs[i].addr = rnd256();
      for (int j = 0; j < 4; j++) vecs[i].lv[j] = rnd256();
      vecs[i].lat = 0; vecs[i].gap = 0; vecs[i].hold = 0; vecs[i].mid = 0;
      vecs[i].exp_hashes = 12;
    end
    vecs[0].addr = '0;
    vecs[1].lat = 1; vecs[1].hold = 1;
    vecs[2].lat = 3; vecs[2].gap = 2; vecs[2].mid = 1;
    vecs[3].addr = '1; vecs[3].hold = 1; vecs[3].mid = 1;
    for (int i = 0; i < 4; i++) begin
      ref_tree(vecs[i].seed, vecs[i].addr, vecs[i].lv, 1'b0, r);
      vecs[i].exp_root = r;
    end

    reset = 1'b1; start = 1'b0; leaf_valid = 1'b0;
    pub_seed = '0; hash_addr = '0; leaf_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 1025'(busy), 1025'(0));
    chk("rst_done", 1025'(done), 1025'(0));
    chk("rst_leaf_ready", 1025'(leaf_ready), 1025'(0));
    chk("rst_hash_start", 1025'(hash_start), 1025'(0));
    chk("rst_root", 1025'(root_out), 1025'(0));
    chk("rst_hash_data", 1025'(hash_data_in), 1025'(0));
    chk("rst_msg_len", 1025'(message_length), 1025'(0));
    reset = 1'b0;

    for (int i = 0; i < 4; i++) run_tree(vecs[i]);

    // Reset while the block waits on the bm0 PRF
    exp_q.delete(); root_exp_q.delete();
    nhash = 0; first_n = 0;
    hash_lat = 4;
    ref_tree(vecs[1].seed, vecs[1].addr, vecs[1].lv, 1'b1, r);
    pub_seed = vecs[1].seed; hash_addr = vecs[1].addr; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    feed_leaf(vecs[1].lv[0]);
    feed_leaf(vecs[1].lv[1]);
    leaf_valid = 1'b0;
    t = 0;
    while (nhash < 2 && t < 300) begin @(negedge clk); t++; end
    chk("reach_prf_bm0", 1025'(nhash), 1025'(2));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_busy", 1025'(busy), 1025'(0));
    chk("mid_rst_hash_start", 1025'(hash_start), 1025'(0));
    chk("mid_rst_hash_data", 1025'(hash_data_in), 1025'(0));
    chk("mid_rst_root", 1025'(root_out), 1025'(0));
    exp_q.delete();
    bad = 0;
    stale_done = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 1) stale_done = 1'b0;
      if (busy || hash_start || done) bad++;
    end
    chk("stale_done_ignored", 1025'(bad), 1025'(0));
    $display("[TB] reset during PRF_BM0 applied, stale hash_done driven");
    run_tree(vecs[2]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
